// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: decodes the F1 start-light thermometer bus and times the driver's reaction from lights-out.
// Define F1_BEST_TIME_EN to add the best_time output (running minimum of react_time).
module f1_reaction_timer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [7:0]       lights,
    input  logic             btn,
    output logic [CNT_W-1:0] react_time,
    output logic             time_valid,
    output logic             jump_start,
    output logic             fault,
    output logic             timeout,
`ifdef F1_BEST_TIME_EN
    output logic [CNT_W-1:0] best_time,
`endif
    output logic             busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARMING, S_ALL_ON, S_TIMING, S_DONE, S_JUMP, S_FAULT, S_TOUT
    } state_t;

    localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT);

    state_t           r_state, w_state;
    logic [7:0]       r_exp, w_exp;
    logic [CNT_W-1:0] r_cnt, w_cnt, r_react, w_react, w_cnt_inc;
    logic             r_btn_q, r_valid, w_valid, r_jump, w_jump, r_fault, w_fault, r_to, w_to;
    logic             w_press;
    logic [7:0]       w_thermo_next;

    assign w_press       = btn & ~r_btn_q;
    assign w_thermo_next = {r_exp[6:0], 1'b1};
    assign w_cnt_inc     = (tick && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;

    always_comb begin
        w_state = r_state;
        w_exp   = r_exp;
        w_cnt   = r_cnt;
        w_react = r_react;
        w_valid = 1'b0;
        w_jump  = r_jump;
        w_fault = r_fault;
        w_to    = r_to;
        case (r_state)
            S_IDLE: if (lights == 8'h01) begin
                w_state = S_ARMING;
                w_exp   = 8'h01;
            end
            S_ARMING: if (w_press) begin
                w_state = S_JUMP;
                w_jump  = 1'b1;
            end else if (lights == w_thermo_next) begin
                w_exp   = lights;
                w_state = (lights == 8'hFF) ? S_ALL_ON : S_ARMING;
            end else if (lights != r_exp) begin
                w_state = S_FAULT;
                w_fault = 1'b1;
            end
            S_ALL_ON: if (w_press) begin
                w_state = S_JUMP;
                w_jump  = 1'b1;
            end else if (lights == 8'h00) begin
                w_state = S_TIMING;
                w_cnt   = '0;
            end else if (lights != 8'hFF) begin
                w_state = S_FAULT;
                w_fault = 1'b1;
            end
            // A press always wins over a simultaneous fault or timeout
            S_TIMING: begin
                w_cnt = w_cnt_inc;
                if (w_press) begin
                    w_state = S_DONE;
                    w_react = w_cnt_inc;
                    w_valid = 1'b1;
                end else if (lights != 8'h00) begin
                    w_state = S_FAULT;
                    w_fault = 1'b1;
                end else if (w_cnt_inc >= LIM) begin
                    w_state = S_TOUT;
                    w_to    = 1'b1;
                end
            end
            default: if (lights == 8'h01) begin
                w_state = S_ARMING;
                w_exp   = 8'h01;
                w_jump  = 1'b0;
                w_fault = 1'b0;
                w_to    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_cnt   <= '0;
            r_react <= '0;
            r_valid <= 1'b0;
            r_jump  <= 1'b0;
            r_fault <= 1'b0;
            r_to    <= 1'b0;
            r_btn_q <= 1'b0;
        end else begin
            r_state <= w_state;
            r_exp   <= w_exp;
            r_cnt   <= w_cnt;
            r_react <= w_react;
            r_valid <= w_valid;
            r_jump  <= w_jump;
            r_fault <= w_fault;
            r_to    <= w_to;
            r_btn_q <= btn;
        end
    end

`ifdef F1_BEST_TIME_EN
    logic [CNT_W-1:0] r_best;
    always_ff @(posedge clk)
        r_best <= rst ? '1 : (w_valid && w_react < r_best) ? w_react : r_best;
    assign best_time = r_best;
`endif

    assign react_time = r_react;
    assign time_valid = r_valid;
    assign jump_start = r_jump;
    assign fault      = r_fault;
    assign timeout    = r_to;
    assign busy       = (r_state == S_ARMING) || (r_state == S_ALL_ON) || (r_state == S_TIMING);
endmodule
